// File: rtl/ms_counter_ctrl_if.sv
// Button-pulse inputs and counter-control outputs of the millisecond counter controller.
interface ms_counter_ctrl_if #(
  parameter int CNT_W = 7
);
  logic             START;
  logic             STOP;
  logic             CLEAR;
  logic             LAP;
  logic             CNT_EN;
  logic             CNT_RST;
  logic             WRAP;
  logic             RUNNING;
  logic [CNT_W-1:0] MS_COUNT;
  logic [CNT_W-1:0] LAP_VALUE;
  logic             LAP_VALID;

  modport master (
    output START, STOP, CLEAR, LAP,
    input  CNT_EN, CNT_RST, WRAP, RUNNING, MS_COUNT, LAP_VALUE, LAP_VALID
  );

  modport slave (
    input  START, STOP, CLEAR, LAP,
    output CNT_EN, CNT_RST, WRAP, RUNNING, MS_COUNT, LAP_VALUE, LAP_VALID
  );
endinterface

// File: rtl/ms_counter_ctrl.sv
// Run/pause/clear controller: divides CLK into 1 ms ticks, drives counter EN/RST pulses,
// wraps at MS_LIMIT and keeps a mirror of the count for lap capture.
//
// state | meaning
// IDLE  | stopped at zero, prescaler forced to 0
// RUN   | prescaler advancing, ticks drive the counter
// PAUSE | prescaler and count held, partial millisecond kept
module ms_counter_ctrl #(
  parameter int CLK_PER_MS = 100000,
  parameter int PRE_W      = 17,
  parameter int MS_LIMIT   = 100,
  parameter int CNT_W      = 7
) (
  input  logic             CLK,
  input  logic             RST,
  ms_counter_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_MS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MS_LIMIT - 1);

  state_t           state, state_nxt;
  logic [PRE_W-1:0] pre, pre_nxt;
  logic [CNT_W-1:0] ms_count, ms_count_nxt;
  logic [CNT_W-1:0] lap_value, lap_value_nxt;
  logic             lap_valid, lap_valid_nxt;
  logic             cnt_en, cnt_en_nxt;
  logic             cnt_rst, cnt_rst_nxt;
  logic             wrap, wrap_nxt;
  logic             tick;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      pre       <= '0;
      ms_count  <= '0;
      lap_value <= '0;
      lap_valid <= 1'b0;
      cnt_en    <= 1'b0;
      cnt_rst   <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      state     <= state_nxt;
      pre       <= pre_nxt;
      ms_count  <= ms_count_nxt;
      lap_value <= lap_value_nxt;
      lap_valid <= lap_valid_nxt;
      cnt_en    <= cnt_en_nxt;
      cnt_rst   <= cnt_rst_nxt;
      wrap      <= wrap_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pre_nxt       = pre;
    ms_count_nxt  = ms_count;
    lap_value_nxt = lap_value;
    lap_valid_nxt = lap_valid;
    cnt_en_nxt    = 1'b0;
    cnt_rst_nxt   = 1'b0;
    wrap_nxt      = 1'b0;
    tick          = 1'b0;

    // Mirror follows the counter: it moves on the edge that ends an EN/RST pulse.
    if (cnt_en) begin
      ms_count_nxt = ms_count + 1'b1;
    end else if (cnt_rst) begin
      ms_count_nxt = '0;
    end

    if (bus.CLEAR) begin
      state_nxt     = IDLE;
      pre_nxt       = '0;
      ms_count_nxt  = '0;
      cnt_rst_nxt   = 1'b1;
      lap_value_nxt = '0;
      lap_valid_nxt = 1'b0;
    end else begin
      if (bus.LAP && state != IDLE) begin
        lap_value_nxt = ms_count;
        lap_valid_nxt = 1'b1;
      end

      unique case (state)
        IDLE: begin
          pre_nxt = '0;
          if (bus.START) state_nxt = RUN;
        end
        RUN: begin
          // STOP beats a tick on the same edge; the prescaler then holds at PRE_LAST.
          if (bus.STOP) begin
            state_nxt = PAUSE;
          end else if (pre == PRE_LAST) begin
            pre_nxt = '0;
            tick    = 1'b1;
          end else begin
            pre_nxt = pre + 1'b1;
          end
        end
        PAUSE: begin
          if (bus.START) state_nxt = RUN;
        end
        default: state_nxt = IDLE;
      endcase

      if (tick) begin
        if (ms_count == CNT_LAST) begin
          cnt_rst_nxt = 1'b1;
          wrap_nxt    = 1'b1;
        end else begin
          cnt_en_nxt  = 1'b1;
        end
      end
    end
  end

  assign bus.CNT_EN    = cnt_en;
  assign bus.CNT_RST   = cnt_rst;
  assign bus.WRAP      = wrap;
  assign bus.RUNNING   = (state == RUN);
  assign bus.MS_COUNT  = ms_count;
  assign bus.LAP_VALUE = lap_value;
  assign bus.LAP_VALID = lap_valid;

endmodule

// File: tb/tb_ms_counter_ctrl.sv
// Directed bench for ms_counter_ctrl with CLK_PER_MS=4, MS_LIMIT=5.
module tb_ms_counter_ctrl;

  logic CLK;
  logic RST;
  int   checks;
  int   errors;
  logic seen;

  ms_counter_ctrl_if #(.CNT_W(3)) bus ();

  ms_counter_ctrl #(
    .CLK_PER_MS(4),
    .PRE_W     (3),
    .MS_LIMIT  (5),
    .CNT_W     (3)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n edges; outputs are sampled 1 time unit after each edge.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      chk("en_rst_excl", {31'd0, bus.CNT_EN & bus.CNT_RST}, 32'd0);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cnt_en"},    {31'd0, bus.CNT_EN},    32'd0);
    chk({tag, "_cnt_rst"},   {31'd0, bus.CNT_RST},   32'd0);
    chk({tag, "_wrap"},      {31'd0, bus.WRAP},      32'd0);
    chk({tag, "_running"},   {31'd0, bus.RUNNING},   32'd0);
    chk({tag, "_ms_count"},  {29'd0, bus.MS_COUNT},  32'd0);
    chk({tag, "_lap_value"}, {29'd0, bus.LAP_VALUE}, 32'd0);
    chk({tag, "_lap_valid"}, {31'd0, bus.LAP_VALID}, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RST = 1'b1;
    bus.START = 1'b0;
    bus.STOP  = 1'b0;
    bus.CLEAR = 1'b0;
    bus.LAP   = 1'b0;
    cyc(2);
    chk_reset_vals("reset");
    RST = 1'b0;

    // Basic run: START at edge 0, ticks at edges 4, 8, 12.
    bus.START = 1'b1; cyc(1); bus.START = 1'b0;
    chk("run_running", {31'd0, bus.RUNNING}, 32'd1);
    chk("run_no_en0",  {31'd0, bus.CNT_EN},  32'd0);
    for (int k = 1; k <= 3; k++) begin
      cyc(3);
      chk("run_pre_en",  {31'd0, bus.CNT_EN},  32'd0);
      chk("run_ms",      {29'd0, bus.MS_COUNT}, 32'(k - 1));
      cyc(1);
      chk("run_en",      {31'd0, bus.CNT_EN},  32'd1);
      chk("run_rst_low", {31'd0, bus.CNT_RST}, 32'd0);
    end
    cyc(1);
    chk("run_ms3", {29'd0, bus.MS_COUNT}, 32'd3);

    // Wrap: 4th tick at edge 16, 5th at edge 20, 6th at edge 24.
    cyc(3);
    chk("tick4_en", {31'd0, bus.CNT_EN}, 32'd1);
    cyc(1);
    chk("tick4_ms", {29'd0, bus.MS_COUNT}, 32'd4);
    cyc(3);
    chk("wrap_rst",   {31'd0, bus.CNT_RST}, 32'd1);
    chk("wrap_pulse", {31'd0, bus.WRAP},    32'd1);
    chk("wrap_no_en", {31'd0, bus.CNT_EN},  32'd0);
    cyc(1);
    chk("wrap_ms0",     {29'd0, bus.MS_COUNT}, 32'd0);
    chk("wrap_one_cyc", {31'd0, bus.WRAP},     32'd0);
    cyc(3);
    chk("tick6_en",  {31'd0, bus.CNT_EN},  32'd1);
    chk("tick6_rst", {31'd0, bus.CNT_RST}, 32'd0);
    cyc(1);
    chk("tick6_ms", {29'd0, bus.MS_COUNT}, 32'd1);

    // Lap in RUN at MS_COUNT=2 (edge 29), then tick at edge 32 makes MS_COUNT=3.
    cyc(4);
    bus.LAP = 1'b1; cyc(1); bus.LAP = 1'b0;
    chk("lap_run2_val",   {29'd0, bus.LAP_VALUE}, 32'd2);
    chk("lap_run2_valid", {31'd0, bus.LAP_VALID}, 32'd1);
    cyc(4);
    chk("pre_pause_ms", {29'd0, bus.MS_COUNT}, 32'd3);

    // STOP sampled with the prescaler at 2: two increments remain after resume.
    bus.STOP = 1'b1; cyc(1); bus.STOP = 1'b0;
    chk("pause_running", {31'd0, bus.RUNNING}, 32'd0);
    bus.LAP = 1'b1; cyc(1); bus.LAP = 1'b0;
    chk("lap_pause_val",   {29'd0, bus.LAP_VALUE}, 32'd3);
    chk("lap_pause_valid", {31'd0, bus.LAP_VALID}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      seen = seen | bus.CNT_EN | bus.CNT_RST;
    end
    chk("pause_no_pulse", {31'd0, seen}, 32'd0);
    chk("pause_ms_held",  {29'd0, bus.MS_COUNT}, 32'd3);
    bus.START = 1'b1; cyc(1); bus.START = 1'b0;
    chk("resume_running", {31'd0, bus.RUNNING}, 32'd1);
    chk("resume_no_en0",  {31'd0, bus.CNT_EN},  32'd0);
    cyc(1);
    chk("resume_no_en1", {31'd0, bus.CNT_EN}, 32'd0);
    cyc(1);
    chk("resume_en", {31'd0, bus.CNT_EN}, 32'd1);
    cyc(1);
    chk("resume_ms4", {29'd0, bus.MS_COUNT}, 32'd4);

    // STOP on a tick edge (prescaler at 3, count at 4 so the tick would wrap).
    cyc(2);
    bus.STOP = 1'b1; cyc(1); bus.STOP = 1'b0;
    chk("stoptick_no_en",  {31'd0, bus.CNT_EN},  32'd0);
    chk("stoptick_no_rst", {31'd0, bus.CNT_RST}, 32'd0);
    chk("stoptick_paused", {31'd0, bus.RUNNING}, 32'd0);
    cyc(3);
    chk("stoptick_held", {31'd0, bus.WRAP | bus.CNT_RST | bus.CNT_EN}, 32'd0);
    bus.START = 1'b1; cyc(1); bus.START = 1'b0;
    chk("stoptick_start_edge", {31'd0, bus.CNT_RST}, 32'd0);
    cyc(1);
    chk("stoptick_wrap_rst", {31'd0, bus.CNT_RST}, 32'd1);
    chk("stoptick_wrap",     {31'd0, bus.WRAP},    32'd1);
    cyc(1);
    chk("stoptick_ms0", {29'd0, bus.MS_COUNT}, 32'd0);
    cyc(4);
    chk("pre_clear_ms1", {29'd0, bus.MS_COUNT}, 32'd1);

    // CLEAR and START together: CLEAR wins.
    bus.CLEAR = 1'b1; bus.START = 1'b1; cyc(1); bus.CLEAR = 1'b0; bus.START = 1'b0;
    chk("clr_running",   {31'd0, bus.RUNNING},   32'd0);
    chk("clr_cnt_rst",   {31'd0, bus.CNT_RST},   32'd1);
    chk("clr_ms",        {29'd0, bus.MS_COUNT},  32'd0);
    chk("clr_lap_valid", {31'd0, bus.LAP_VALID}, 32'd0);
    chk("clr_lap_value", {29'd0, bus.LAP_VALUE}, 32'd0);
    cyc(1);
    chk("clr_rst_one_cyc", {31'd0, bus.CNT_RST}, 32'd0);
    chk("clr_still_idle",  {31'd0, bus.RUNNING}, 32'd0);

    // LAP in IDLE is ignored; IDLE never ticks.
    bus.LAP = 1'b1; cyc(1); bus.LAP = 1'b0;
    chk("lap_idle_valid", {31'd0, bus.LAP_VALID}, 32'd0);
    chk("lap_idle_value", {29'd0, bus.LAP_VALUE}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      seen = seen | bus.CNT_EN;
    end
    chk("idle_no_en", {31'd0, seen}, 32'd0);

    // Fresh run to MS_COUNT=3 then lap in RUN.
    bus.START = 1'b1; cyc(1); bus.START = 1'b0;
    cyc(13);
    chk("run2_ms3", {29'd0, bus.MS_COUNT}, 32'd3);
    bus.LAP = 1'b1; cyc(1); bus.LAP = 1'b0;
    chk("lap_run3_val",   {29'd0, bus.LAP_VALUE}, 32'd3);
    chk("lap_run3_valid", {31'd0, bus.LAP_VALID}, 32'd1);

    // Reset mid-run with MS_COUNT=2 and prescaler at 1.
    bus.CLEAR = 1'b1; cyc(1); bus.CLEAR = 1'b0;
    bus.START = 1'b1; cyc(1); bus.START = 1'b0;
    cyc(9);
    chk("prerst_ms2", {29'd0, bus.MS_COUNT}, 32'd2);
    RST = 1'b1; cyc(1); RST = 1'b0;
    chk_reset_vals("midrst");
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      seen = seen | bus.CNT_EN | bus.RUNNING;
    end
    chk("midrst_stays_idle", {31'd0, seen}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
